// File: rtl/fir_pkg.sv
// Shared types and sizing constants for the FIR sequencing controller.
package fir_pkg;

  localparam int COEF_AW  = 5;
  localparam int SAMP_AW  = 14;
  localparam int MAX_TAPS = 32;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    TAPS,
    DRAIN,
    WRITE,
    FINISH
  } fir_state_t;

endpackage

// File: rtl/fir_delay_line.sv
// Fixed-depth shift register; cleared on reset so no stale strobes survive an abort.
module fir_delay_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  // shift d through DEPTH register stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/fir_seq_ctrl.sv
// FIR sequencer: walks samples n and taps k, drives RAM addresses and MAC strobes,
// and writes one result per sample. Outputs are registered from the current state.
module fir_seq_ctrl #(
  parameter int          COEF_AW = fir_pkg::COEF_AW,
  parameter int          SAMP_AW = fir_pkg::SAMP_AW,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned MAC_LAT = 1
) (
  input  logic               clk_b,
  input  logic               rst_n,
  input  logic               Start,
  input  logic [5:0]         Ile_wsp,
  input  logic [SAMP_AW-1:0] Ile_probek,
  output logic               pracuje,
  output logic               DONE,
  output logic               FSM_MUX_CDC,
  output logic [COEF_AW-1:0] address_FIR,
  output logic [SAMP_AW-1:0] x_addr,
  output logic               x_rd,
  output logic               mac_clr,
  output logic               mac_en,
  output logic               mac_zero,
  output logic [SAMP_AW-1:0] y_addr,
  output logic               y_wr
);

  import fir_pkg::*;

  localparam int unsigned DRAIN_LEN = RD_LAT + MAC_LAT;
  localparam logic [5:0]  TAP_CLAMP = 6'(MAX_TAPS);

  fir_state_t         state;
  logic [5:0]         n_taps;
  logic [SAMP_AW-1:0] m_samp;
  logic [SAMP_AW-1:0] n;
  logic [COEF_AW-1:0] k;
  logic [7:0]         d_cnt;
  logic               issue_valid;
  logic               issue_zero;
  logic [SAMP_AW:0]   diff;

  // n-k with a spare sign bit; negative means the tap reaches before x[0]
  assign diff = {1'b0, n} - {{(SAMP_AW + 1 - COEF_AW){1'b0}}, k};

  // sequencing FSM with counters and registered strobes
  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      n_taps      <= '0;
      m_samp      <= '0;
      n           <= '0;
      k           <= '0;
      d_cnt       <= '0;
      pracuje     <= 1'b0;
      FSM_MUX_CDC <= 1'b0;
      DONE        <= 1'b0;
      address_FIR <= '0;
      x_addr      <= '0;
      x_rd        <= 1'b0;
      mac_clr     <= 1'b0;
      y_addr      <= '0;
      y_wr        <= 1'b0;
      issue_valid <= 1'b0;
      issue_zero  <= 1'b0;
    end else begin
      pracuje     <= 1'b0;
      FSM_MUX_CDC <= 1'b0;
      DONE        <= 1'b0;
      address_FIR <= '0;
      x_addr      <= '0;
      x_rd        <= 1'b0;
      mac_clr     <= 1'b0;
      y_addr      <= '0;
      y_wr        <= 1'b0;
      issue_valid <= 1'b0;
      issue_zero  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (Start) begin
            n_taps <= (Ile_wsp > TAP_CLAMP) ? TAP_CLAMP : Ile_wsp;
            m_samp <= Ile_probek;
            n      <= '0;
            state  <= (Ile_wsp == 6'd0 || Ile_probek == '0) ? FINISH : CLR;
          end
        end
        CLR: begin
          pracuje     <= 1'b1;
          FSM_MUX_CDC <= 1'b1;
          mac_clr     <= 1'b1;
          k           <= '0;
          state       <= TAPS;
        end
        TAPS: begin
          pracuje     <= 1'b1;
          FSM_MUX_CDC <= 1'b1;
          address_FIR <= k;
          issue_valid <= 1'b1;
          if (!diff[SAMP_AW]) begin
            x_rd   <= 1'b1;
            x_addr <= diff[SAMP_AW-1:0];
          end else begin
            issue_zero <= 1'b1;
          end
          if ({1'b0, k} == n_taps - 1'b1) begin
            d_cnt <= '0;
            state <= DRAIN;
          end else begin
            k <= k + 1'b1;
          end
        end
        DRAIN: begin
          pracuje     <= 1'b1;
          FSM_MUX_CDC <= 1'b1;
          if (d_cnt == 8'(DRAIN_LEN - 1)) state <= WRITE;
          else d_cnt <= d_cnt + 1'b1;
        end
        WRITE: begin
          pracuje     <= 1'b1;
          FSM_MUX_CDC <= 1'b1;
          y_wr        <= 1'b1;
          y_addr      <= n;
          if (n == m_samp - 1'b1) begin
            state <= FINISH;
          end else begin
            n     <= n + 1'b1;
            state <= CLR;
          end
        end
        FINISH: begin
          DONE  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // align issue strobes with coefficient/sample RAM read data
  fir_delay_line #(
    .DEPTH (RD_LAT),
    .WIDTH (2)
  ) u_issue_dly (
    .clk   (clk_b),
    .rst_n (rst_n),
    .d     ({issue_valid, issue_zero}),
    .q     ({mac_en, mac_zero})
  );

endmodule

// File: doc/fir_seq_ctrl.md
Name: fir_seq_ctrl

Overview:
- FIR sequencing FSM in the clk_b domain.
- On a Start pulse from the control registers, it computes y[n] = sum over k=0..N-1 of h[k]*x[n-k] for n=0..M-1.
- Each tap drives the coefficient RAM address (address_FIR), the sample-memory read address, and the MAC enable/clear strobes; each result is written back to output memory.
- It owns pracuje, DONE and FSM_MUX_CDC, which gate APB/CDC access to the coefficient RAM.

Parameters:
- COEF_AW, 5, coefficient RAM address width (max 32 taps).
- SAMP_AW, 14, sample/result memory address width.
- RD_LAT, 1, read latency of coefficient and sample RAMs, in cycles (>=1).
- MAC_LAT, 1, cycles from mac_en until the accumulator holds the updated sum (>=1).

Ports:
- clk_b  in  1  processing clock.
- rst_n  in  1  asynchronous active-low reset.
- Start  in  1  one-cycle start pulse from ctrl_registers.
- Ile_wsp  in  6  number of taps N.
- Ile_probek  in  14  number of samples M.
- pracuje  out  1  busy flag.
- DONE  out  1  one-cycle completion pulse.
- FSM_MUX_CDC  out  1  1 = coefficient RAM addressed by address_FIR.
- address_FIR  out  COEF_AW  coefficient index k.
- x_addr  out  SAMP_AW  sample address n-k.
- x_rd  out  1  sample read strobe.
- mac_clr  out  1  clear accumulator.
- mac_en  out  1  accumulate h*x, aligned to RAM data.
- mac_zero  out  1  with mac_en: use x=0 (n<k).
- y_addr  out  SAMP_AW  result address n.
- y_wr  out  1  result write strobe.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; all outputs 0.
  - Counters n and k and the delay lines are cleared.
  - Reset mid-run aborts immediately with no DONE pulse.
- States: IDLE, CLR, TAPS, DRAIN, WRITE, FINISH.
- IDLE:
  - Start=1 latches N=min(Ile_wsp,32) and M=Ile_probek, and sets n=0.
  - If N==0 or M==0, go to FINISH. Otherwise go to CLR.
  - Start is ignored in every other state; later changes to Ile_* have no effect until the next run.
- Outputs by state:
  - pracuje=1 and FSM_MUX_CDC=1 in CLR, TAPS, DRAIN, WRITE.
  - Both are 0 in IDLE and FINISH.
- CLR (1 cycle): mac_clr=1, k=0. Next state TAPS.
- TAPS (N cycles, k=0..N-1):
  - address_FIR=k.
  - If n>=k: x_addr=n-k, x_rd=1, issue_zero=0.
  - Else: x_rd=0, x_addr=0, issue_zero=1.
  - An issue-valid bit and issue_zero enter an RD_LAT-deep shift register; its output drives mac_en/mac_zero.
  - mac_en is therefore high for exactly N cycles, starting RD_LAT cycles after the first TAPS cycle.
  - After k=N-1, go to DRAIN.
- DRAIN: lasts RD_LAT+MAC_LAT cycles, so the last product is in the accumulator. Next state WRITE.
- WRITE (1 cycle):
  - y_wr=1, y_addr=n.
  - If n==M-1, go to FINISH; else n++ and go to CLR.
- FINISH (1 cycle): DONE=1, then IDLE.
- Per-sample period is N+RD_LAT+MAC_LAT+2 cycles (N+4 at defaults). Total run is M*(N+4)+1 cycles from Start to DONE.
- Arithmetic:
  - n-k is computed in SAMP_AW+1 bits; the sign bit selects the zero tap.
  - Counters never wrap: k<=31, n<=M-1<=16383.
- While busy, APB writes to the coefficient RAM are blocked externally (wr && !pracuje). This block has no obligation there beyond holding pracuje.
- Boundaries:
  - N=1: TAPS is 1 cycle.
  - Ile_wsp>=32: clamp to N=32.
  - M=1: single WRITE then FINISH.
  - Start in the same cycle as FINISH is ignored.

Decomposition:
- Package fir_pkg holds:
  - typedef enum logic [2:0] fir_state_t {IDLE, CLR, TAPS, DRAIN, WRITE, FINISH};
  - constants COEF_AW, SAMP_AW, MAX_TAPS=32.
- Sub-module fir_delay_line (parameterised depth/width shift register, reset to 0) aligns issue-valid/zero to mac_en/mac_zero. It is reused for DRAIN timing checks.

Test Plan:
- Reset during TAPS (n=2, k=3) -> all outputs 0 next cycle; no DONE; a fresh Start runs the full sequence.
- Start with N=3, M=4 -> pracuje is high for 28 cycles and DONE follows. Per sample n: x_addr sequence n,n-1,n-2 with zero taps where n<k. y_wr occurs 4 times at y_addr 0..3.
- N=0, M=10 -> DONE two cycles after Start; pracuje, y_wr and mac_en never assert.
- Ile_wsp=40, M=1 -> address_FIR runs 0..31, then wraps to none; exactly 32 mac_en cycles; one y_wr at 0.
- Start pulsed again mid-run, and Ile_wsp/Ile_probek changed mid-run -> sequence unchanged; a single DONE.
- Sample n=1, N=3 -> mac_zero=1 only on the k=2 tap; mac_en is delayed exactly RD_LAT cycles from address_FIR=k. The bench checks this with RD_LAT=1 and with RD_LAT=2.
